// File: rtl/mod_counter_ctrl.sv
// Programmable modulus counter controller: accepts (N, reps) commands, counts 0..N-1, pulses wrap/done.
// Optional macro MCC_PAUSE_EN adds a pause input that holds the run.
module mod_counter_ctrl #(
  parameter int WIDTH = 3,
  parameter int REPW  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_mod,
  input  logic [REPW-1:0]  cmd_reps,
  input  logic             stop,
`ifdef MCC_PAUSE_EN
  input  logic             pause,
`endif
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             done,
  output logic             busy
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] term_q, term_d;
  logic [REPW-1:0]  reps_q, reps_d;
  logic [REPW-1:0]  wcnt_q, wcnt_d;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;
  logic [REPW-1:0]  wcntInc;
  logic             holdRun;

  assign wcntInc = wcnt_q + 1'b1;

`ifdef MCC_PAUSE_EN
  assign holdRun = pause;
`else
  assign holdRun = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      term_q  <= '0;
      reps_q  <= '0;
      wcnt_q  <= '0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      term_q  <= term_d;
      reps_q  <= reps_d;
      wcnt_q  <= wcnt_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
    end
  end

  // Modulus 0 maps to all-ones terminal because N-1 wraps naturally in WIDTH bits.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    term_d  = term_q;
    reps_d  = reps_q;
    wcnt_d  = wcnt_q;
    wrap_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        count_d = '0;
        if (cmd_valid) begin
          term_d  = cmd_mod - 1'b1;
          reps_d  = cmd_reps;
          wcnt_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          count_d = '0;
          state_d = IDLE;
        end else if (holdRun) begin
          count_d = count_q;
        end else if (count_q != term_q) begin
          count_d = count_q + 1'b1;
        end else begin
          count_d = '0;
          wrap_d  = 1'b1;
          if (reps_q != '0 && wcntInc == reps_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            wcnt_d = wcntInc;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q == RUN);
  assign cmd_ready = !busy;
  assign count     = count_q;
  assign wrap      = wrap_q;
  assign done      = done_q;

endmodule

// File: tb/tb_mod_counter_ctrl.sv
// Directed self-checking bench for mod_counter_ctrl (WIDTH=3, REPW=4); pause scenario needs MCC_PAUSE_EN.
module tb_mod_counter_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_mod;
  logic [3:0] cmd_reps;
  logic       stop;
`ifdef MCC_PAUSE_EN
  logic       pause;
`endif
  logic [2:0] count;
  logic       wrap;
  logic       done;
  logic       busy;

  int passCount  = 0;
  int checkCount = 0;

  mod_counter_ctrl #(.WIDTH(3), .REPW(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_mod   (cmd_mod),
    .cmd_reps  (cmd_reps),
    .stop      (stop),
`ifdef MCC_PAUSE_EN
    .pause     (pause),
`endif
    .count     (count),
    .wrap      (wrap),
    .done      (done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then settle so inputs and samples sit away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checkCount++; if (count !== 3'd0) $display("FAIL reset_count: got %0d expected 0", count); else passCount++;
    checkCount++; if (wrap !== 1'b0) $display("FAIL reset_wrap: got %0b expected 0", wrap); else passCount++;
    checkCount++; if (done !== 1'b0) $display("FAIL reset_done: got %0b expected 0", done); else passCount++;
    checkCount++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b expected 0", busy); else passCount++;
    checkCount++; if (cmd_ready !== 1'b1) $display("FAIL reset_ready: got %0b expected 1", cmd_ready); else passCount++;
  endtask

  task automatic test_single();
    cmd_valid = 1'b1; cmd_mod = 3'd7; cmd_reps = 4'd1;
    tick();
    cmd_valid = 1'b0;
    checkCount++; if (count !== 3'd0) $display("FAIL single_accept_count: got %0d expected 0", count); else passCount++;
    checkCount++; if (busy !== 1'b1) $display("FAIL single_accept_busy: got %0b expected 1", busy); else passCount++;
    for (int e = 1; e <= 6; e++) begin
      tick();
      checkCount++; if (count !== e[2:0]) $display("FAIL single_count_e%0d: got %0d expected %0d", e, count, e); else passCount++;
      checkCount++; if (wrap !== 1'b0) $display("FAIL single_nowrap_e%0d: got %0b expected 0", e, wrap); else passCount++;
    end
    tick();
    checkCount++; if (wrap !== 1'b1) $display("FAIL single_wrap: got %0b expected 1", wrap); else passCount++;
    checkCount++; if (done !== 1'b1) $display("FAIL single_done: got %0b expected 1", done); else passCount++;
    checkCount++; if (busy !== 1'b0) $display("FAIL single_busy_end: got %0b expected 0", busy); else passCount++;
    checkCount++; if (cmd_ready !== 1'b1) $display("FAIL single_ready_end: got %0b expected 1", cmd_ready); else passCount++;
    checkCount++; if (count !== 3'd0) $display("FAIL single_count_end: got %0d expected 0", count); else passCount++;
    tick();
    checkCount++; if (wrap !== 1'b0 || done !== 1'b0) $display("FAIL single_pulse_width: got wrap=%0b done=%0b expected 0 0", wrap, done); else passCount++;
  endtask

  task automatic test_mod0();
    logic [2:0] expCount;
    logic       expWrap;
    logic       expDone;
    cmd_valid = 1'b1; cmd_mod = 3'd0; cmd_reps = 4'd2;
    tick();
    cmd_valid = 1'b0;
    for (int e = 1; e <= 16; e++) begin
      tick();
      expCount = e[2:0];
      expWrap  = (e % 8 == 0);
      expDone  = (e == 16);
      checkCount++; if (count !== expCount) $display("FAIL mod0_count_e%0d: got %0d expected %0d", e, count, expCount); else passCount++;
      checkCount++; if (wrap !== expWrap) $display("FAIL mod0_wrap_e%0d: got %0b expected %0b", e, wrap, expWrap); else passCount++;
      checkCount++; if (done !== expDone) $display("FAIL mod0_done_e%0d: got %0b expected %0b", e, done, expDone); else passCount++;
    end
    tick();
    checkCount++; if (busy !== 1'b0) $display("FAIL mod0_idle_after: got busy=%0b expected 0", busy); else passCount++;
  endtask

  task automatic test_freerun();
    int wrapSeen = 0;
    int doneSeen = 0;
    cmd_valid = 1'b1; cmd_mod = 3'd5; cmd_reps = 4'd0;
    tick();
    cmd_valid = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      tick();
      if (wrap === 1'b1) wrapSeen++;
      if (done === 1'b1) doneSeen++;
    end
    checkCount++; if (busy !== 1'b1) $display("FAIL freerun_still_busy: got %0b expected 1", busy); else passCount++;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    if (done === 1'b1) doneSeen++;
    checkCount++; if (wrapSeen != 8) $display("FAIL freerun_wraps: got %0d expected 8", wrapSeen); else passCount++;
    checkCount++; if (doneSeen != 0) $display("FAIL freerun_dones: got %0d expected 0", doneSeen); else passCount++;
    checkCount++; if (count !== 3'd0) $display("FAIL freerun_stop_count: got %0d expected 0", count); else passCount++;
    checkCount++; if (cmd_ready !== 1'b1) $display("FAIL freerun_stop_ready: got %0b expected 1", cmd_ready); else passCount++;
    checkCount++; if (wrap !== 1'b0) $display("FAIL freerun_stop_wrap: got %0b expected 0", wrap); else passCount++;
  endtask

  task automatic test_stop_terminal();
    cmd_valid = 1'b1; cmd_mod = 3'd3; cmd_reps = 4'd1;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    checkCount++; if (count !== 3'd2) $display("FAIL stopterm_at_term: got %0d expected 2", count); else passCount++;
    stop = 1'b1;
    tick();
    checkCount++; if (wrap !== 1'b0) $display("FAIL stopterm_wrap: got %0b expected 0", wrap); else passCount++;
    checkCount++; if (done !== 1'b0) $display("FAIL stopterm_done: got %0b expected 0", done); else passCount++;
    checkCount++; if (busy !== 1'b0) $display("FAIL stopterm_busy: got %0b expected 0", busy); else passCount++;
    checkCount++; if (count !== 3'd0) $display("FAIL stopterm_count: got %0d expected 0", count); else passCount++;
    tick();
    stop = 1'b0;
    checkCount++; if (busy !== 1'b0 || count !== 3'd0) $display("FAIL stop_in_idle: got busy=%0b count=%0d expected 0 0", busy, count); else passCount++;
  endtask

  task automatic test_back_to_back();
    cmd_valid = 1'b1; cmd_mod = 3'd4; cmd_reps = 4'd1;
    tick();
    for (int e = 1; e <= 3; e++) begin
      tick();
      checkCount++; if (busy !== 1'b1 || cmd_ready !== 1'b0) $display("FAIL b2b_busy_e%0d: got busy=%0b ready=%0b expected 1 0", e, busy, cmd_ready); else passCount++;
      checkCount++; if (count !== e[2:0]) $display("FAIL b2b_count_e%0d: got %0d expected %0d", e, count, e); else passCount++;
    end
    tick();
    checkCount++; if (done !== 1'b1 || cmd_ready !== 1'b1) $display("FAIL b2b_done1: got done=%0b ready=%0b expected 1 1", done, cmd_ready); else passCount++;
    tick();
    cmd_valid = 1'b0;
    checkCount++; if (busy !== 1'b1 || count !== 3'd0) $display("FAIL b2b_second_accept: got busy=%0b count=%0d expected 1 0", busy, count); else passCount++;
    checkCount++; if (done !== 1'b0 || wrap !== 1'b0) $display("FAIL b2b_pulse_clear: got done=%0b wrap=%0b expected 0 0", done, wrap); else passCount++;
    tick(); tick(); tick();
    checkCount++; if (count !== 3'd3) $display("FAIL b2b_second_term: got %0d expected 3", count); else passCount++;
    tick();
    checkCount++; if (done !== 1'b1 || wrap !== 1'b1) $display("FAIL b2b_done2: got done=%0b wrap=%0b expected 1 1", done, wrap); else passCount++;
    tick();
    checkCount++; if (busy !== 1'b0) $display("FAIL b2b_final_idle: got %0b expected 0", busy); else passCount++;
  endtask

  task automatic test_n1();
    cmd_valid = 1'b1; cmd_mod = 3'd1; cmd_reps = 4'd3;
    tick();
    cmd_valid = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      tick();
      checkCount++; if (wrap !== 1'b1 || count !== 3'd0) $display("FAIL n1_wrap_e%0d: got wrap=%0b count=%0d expected 1 0", e, wrap, count); else passCount++;
      checkCount++; if (done !== (e == 3)) $display("FAIL n1_done_e%0d: got %0b expected %0b", e, done, (e == 3)); else passCount++;
    end
    tick();
  endtask

  task automatic test_reset_midrun();
    cmd_valid = 1'b1; cmd_mod = 3'd7; cmd_reps = 4'd3;
    tick();
    cmd_mod = 3'd2;
    tick(); tick(); tick();
    checkCount++; if (count !== 3'd3 || busy !== 1'b1) $display("FAIL midrst_pre: got count=%0d busy=%0b expected 3 1", count, busy); else passCount++;
    reset = 1'b1;
    tick();
    checkCount++; if (count !== 3'd0) $display("FAIL midrst_count: got %0d expected 0", count); else passCount++;
    checkCount++; if (busy !== 1'b0 || cmd_ready !== 1'b1) $display("FAIL midrst_state: got busy=%0b ready=%0b expected 0 1", busy, cmd_ready); else passCount++;
    checkCount++; if (wrap !== 1'b0 || done !== 1'b0) $display("FAIL midrst_pulses: got wrap=%0b done=%0b expected 0 0", wrap, done); else passCount++;
    cmd_valid = 1'b0;
    reset = 1'b0;
    tick();
    checkCount++; if (busy !== 1'b0) $display("FAIL midrst_dropped: got busy=%0b expected 0", busy); else passCount++;
  endtask

`ifdef MCC_PAUSE_EN
  task automatic test_pause();
    cmd_valid = 1'b1; cmd_mod = 3'd4; cmd_reps = 4'd1;
    tick();
    cmd_valid = 1'b0;
    tick(); tick();
    pause = 1'b1;
    for (int p = 0; p < 3; p++) begin
      tick();
      checkCount++; if (count !== 3'd2 || wrap !== 1'b0) $display("FAIL pause_hold_p%0d: got count=%0d wrap=%0b expected 2 0", p, count, wrap); else passCount++;
    end
    pause = 1'b0;
    tick();
    checkCount++; if (count !== 3'd3 || done !== 1'b0) $display("FAIL pause_resume: got count=%0d done=%0b expected 3 0", count, done); else passCount++;
    tick();
    checkCount++; if (done !== 1'b1 || wrap !== 1'b1) $display("FAIL pause_done_late: got done=%0b wrap=%0b expected 1 1", done, wrap); else passCount++;
    tick();
  endtask
`endif

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_mod = 3'd0; cmd_reps = 4'd0; stop = 1'b0;
`ifdef MCC_PAUSE_EN
    pause = 1'b0;
`endif
    test_reset();
    test_single();
    test_mod0();
    test_freerun();
    test_stop_terminal();
    test_back_to_back();
    test_n1();
    test_reset_midrun();
`ifdef MCC_PAUSE_EN
    test_pause();
`endif
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
